core_data_router: RTL and testbench



---
 rtl/core_data_router.sv | 162 ++++++++++++++++
 tb/tb_core_data_router.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_data_router.sv
// Address-decoding router from the core data port to the RAM and peripheral targets.
// Keeps an in-order tag queue so responses return in request order and unmapped accesses complete with an error.
module core_data_router #(
  parameter logic [31:0] RAM_BASE        = 32'h0000_0000,
  parameter logic [31:0] RAM_MASK        = 32'hFFFF_0000,
  parameter logic [31:0] PERI_BASE       = 32'h1A10_0000,
  parameter logic [31:0] PERI_MASK       = 32'hFFFF_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        ram_req,
  output logic [31:0] ram_addr,
  output logic        ram_write,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic        ram_gnt,
  input  logic        ram_rvalid,
  input  logic [31:0] ram_rdata,
  output logic        peri_req,
  output logic [31:0] peri_addr,
  output logic        peri_write,
  output logic [3:0]  peri_be,
  output logic [31:0] peri_wdata,
  input  logic        peri_gnt,
  input  logic        peri_rvalid,
  input  logic [31:0] peri_rdata
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] TGT_RAM  = 2'd0;
  localparam logic [1:0] TGT_PERI = 2'd1;
  localparam logic [1:0] TGT_ERR  = 2'd2;

  logic [1:0]    r_tag [MAX_OUTSTANDING];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_tgt;
  logic [1:0]    w_head;
  logic [1:0]    w_last;
  logic [PW-1:0] w_last_ptr;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_issue_ok;
  logic          w_ram_resp_ok;
  logic          w_peri_resp_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // RAM wins when both regions match.
  always_comb begin
    w_tgt = TGT_ERR;
    if ((data_addr_i & RAM_MASK) == RAM_BASE)
      w_tgt = TGT_RAM;
    else if ((data_addr_i & PERI_MASK) == PERI_BASE)
      w_tgt = TGT_PERI;
  end

  assign w_empty        = (r_cnt == '0);
  assign w_head         = r_tag[r_rptr];
  assign w_last_ptr     = (r_wptr == '0) ? PW'(MAX_OUTSTANDING - 1) : r_wptr - 1'b1;
  assign w_last         = r_tag[w_last_ptr];
  assign w_ram_resp_ok  = !w_empty && (w_head == TGT_RAM);
  assign w_peri_resp_ok = !w_empty && (w_head == TGT_PERI);

  // An ERR head completes on its own the cycle it reaches the head.
  assign w_pop = (w_ram_resp_ok && ram_rvalid) ||
                 (w_peri_resp_ok && peri_rvalid) ||
                 (!w_empty && (w_head == TGT_ERR));

  // A target switch may issue in the cycle the last outstanding response pops.
  assign w_issue_ok = ((r_cnt < CW'(MAX_OUTSTANDING)) || w_pop) &&
                      (w_empty || (w_tgt == w_last) || ((r_cnt == CW'(1)) && w_pop));

  assign ram_req  = data_req_i && w_issue_ok && (w_tgt == TGT_RAM);
  assign peri_req = data_req_i && w_issue_ok && (w_tgt == TGT_PERI);

  always_comb begin
    data_gnt_o = 1'b0;
    case (w_tgt)
      TGT_RAM:  data_gnt_o = ram_req && ram_gnt;
      TGT_PERI: data_gnt_o = peri_req && peri_gnt;
      default:  data_gnt_o = data_req_i && w_issue_ok;
    endcase
  end

  assign w_push = data_gnt_o;

  assign ram_addr   = data_addr_i;
  assign ram_write  = data_we_i;
  assign ram_be     = data_be_i;
  assign ram_wdata  = data_wdata_i;
  assign peri_addr  = data_addr_i;
  assign peri_write = data_we_i;
  assign peri_be    = data_be_i;
  assign peri_wdata = data_wdata_i;

  assign data_rvalid_o = w_pop;
  assign data_err_o    = w_pop && (w_head == TGT_ERR);

  always_comb begin
    data_rdata_o = '0;
    if (w_pop) begin
      case (w_head)
        TGT_RAM:  data_rdata_o = ram_rdata;
        TGT_PERI: data_rdata_o = peri_rdata;
        default:  data_rdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push)
        r_wptr <= ptr_inc(r_wptr);
      if (w_pop)
        r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Tag storage is pure data; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push)
      r_tag[r_wptr] <= w_tgt;
  end

`ifdef CORE_DATA_ROUTER_STRAY_ASSERT
  // Stray responses are dropped; define the macro to flag them (legal after a mid-flight reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ram_rvalid && !w_ram_resp_ok)) else $error("stray ram_rvalid dropped");
      assert (!(peri_rvalid && !w_peri_resp_ok)) else $error("stray peri_rvalid dropped");
    end
  end
`endif

endmodule

// File: tb/tb_core_data_router.sv
// Directed bench for core_data_router: the stimulus pushes expected responses into a scoreboard
// queue and a negedge monitor pops and compares them whenever data_rvalid_o is presented.
module tb_core_data_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        ram_req;
  logic [31:0] ram_addr;
  logic        ram_write;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        ram_gnt;
  logic        ram_rvalid;
  logic [31:0] ram_rdata;
  logic        peri_req;
  logic [31:0] peri_addr;
  logic        peri_write;
  logic [3:0]  peri_be;
  logic [31:0] peri_wdata;
  logic        peri_gnt;
  logic        peri_rvalid;
  logic [31:0] peri_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   gnt_cnt;

  core_data_router dut (
    .clk           (clk),
    .rst           (rst),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .ram_req       (ram_req),
    .ram_addr      (ram_addr),
    .ram_write     (ram_write),
    .ram_be        (ram_be),
    .ram_wdata     (ram_wdata),
    .ram_gnt       (ram_gnt),
    .ram_rvalid    (ram_rvalid),
    .ram_rdata     (ram_rdata),
    .peri_req      (peri_req),
    .peri_addr     (peri_addr),
    .peri_write    (peri_write),
    .peri_be       (peri_be),
    .peri_wdata    (peri_wdata),
    .peri_gnt      (peri_gnt),
    .peri_rvalid   (peri_rvalid),
    .peri_rdata    (peri_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    data_req_i  = 1'b0;
    ram_gnt     = 1'b0;
    ram_rvalid  = 1'b0;
    peri_gnt    = 1'b0;
    peri_rvalid = 1'b0;
  endtask

  task automatic request(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    data_req_i   = 1'b1;
    data_addr_i  = addr;
    data_we_i    = we;
    data_be_i    = 4'hF;
    data_wdata_i = wdata;
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (data_rvalid_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got rdata %h err %b expected no response", data_rdata_o, data_err_o);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", data_rdata_o, e.rdata);
        chk("rsp_err", {31'b0, data_err_o}, {31'b0, e.err});
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    data_addr_i  = '0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_wdata_i = '0;
    ram_rdata    = '0;
    peri_rdata   = '0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_gnt", {31'b0, data_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    chk("rst_err", {31'b0, data_err_o}, 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    chk("rst_ram_req", {31'b0, ram_req}, 32'd0);
    chk("rst_peri_req", {31'b0, peri_req}, 32'd0);
    tick();

    // RAM read, granted immediately, answered one cycle later
    request(32'h0000_0100, 1'b0, 32'h0);
    ram_gnt = 1'b1;
    settle();
    chk("ramrd_ram_req", {31'b0, ram_req}, 32'd1);
    chk("ramrd_peri_req", {31'b0, peri_req}, 32'd0);
    chk("ramrd_gnt", {31'b0, data_gnt_o}, 32'd1);
    chk("ramrd_addr", ram_addr, 32'h0000_0100);
    expect_rsp(32'hCAFE_F00D, 1'b0);
    tick();
    idle();
    ram_rvalid = 1'b1;
    ram_rdata  = 32'hCAFE_F00D;
    settle();
    chk("ramrd_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    chk("ramrd_peri_req_resp", {31'b0, peri_req}, 32'd0);
    tick();
    idle();

    // Peripheral write, gnt after two wait cycles
    gnt_cnt = 0;
    request(32'h1A10_0004, 1'b1, 32'h0000_0041);
    for (int i = 0; i < 3; i++) begin
      peri_gnt = (i == 2);
      settle();
      chk("periwr_req", {31'b0, peri_req}, 32'd1);
      chk("periwr_write", {31'b0, peri_write}, 32'd1);
      chk("periwr_wdata", peri_wdata, 32'h0000_0041);
      chk("periwr_be", {28'b0, peri_be}, 32'hF);
      chk("periwr_ram_req", {31'b0, ram_req}, 32'd0);
      if (data_gnt_o) gnt_cnt++;
      if (i == 2) expect_rsp(32'h1234_5678, 1'b0);
      tick();
    end
    idle();
    peri_rvalid = 1'b1;
    peri_rdata  = 32'h1234_5678;
    settle();
    if (data_gnt_o) gnt_cnt++;
    chk("periwr_gnt_pulses", gnt_cnt, 32'd1);
    chk("periwr_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    tick();
    idle();

    // Unmapped address: local grant, error response next cycle
    request(32'h8000_0000, 1'b0, 32'h0);
    settle();
    chk("err_gnt", {31'b0, data_gnt_o}, 32'd1);
    chk("err_ram_req", {31'b0, ram_req}, 32'd0);
    chk("err_peri_req", {31'b0, peri_req}, 32'd0);
    chk("err_rvalid_n", {31'b0, data_rvalid_o}, 32'd0);
    expect_rsp(32'h0, 1'b1);
    tick();
    idle();
    settle();
    chk("err_rvalid_n1", {31'b0, data_rvalid_o}, 32'd1);
    tick();

    // Target switch while two RAM reads are outstanding
    request(32'h0000_0200, 1'b0, 32'h0);
    ram_gnt = 1'b1;
    settle();
    chk("sw_gnt0", {31'b0, data_gnt_o}, 32'd1);
    expect_rsp(32'h1111_1111, 1'b0);
    tick();
    data_addr_i = 32'h0000_0204;
    settle();
    chk("sw_gnt1", {31'b0, data_gnt_o}, 32'd1);
    expect_rsp(32'h2222_2222, 1'b0);
    tick();
    data_addr_i = 32'h1A10_0000;
    ram_gnt     = 1'b0;
    peri_gnt    = 1'b1;
    settle();
    chk("sw_full_peri_req", {31'b0, peri_req}, 32'd0);
    chk("sw_full_gnt", {31'b0, data_gnt_o}, 32'd0);
    tick();
    ram_rvalid = 1'b1;
    ram_rdata  = 32'h1111_1111;
    settle();
    chk("sw_pop1_peri_req", {31'b0, peri_req}, 32'd0);
    chk("sw_pop1_gnt", {31'b0, data_gnt_o}, 32'd0);
    tick();
    ram_rdata = 32'h2222_2222;
    settle();
    chk("sw_pop2_peri_req", {31'b0, peri_req}, 32'd1);
    chk("sw_pop2_gnt", {31'b0, data_gnt_o}, 32'd1);
    expect_rsp(32'h3333_3333, 1'b0);
    tick();
    idle();
    peri_rvalid = 1'b1;
    peri_rdata  = 32'h3333_3333;
    settle();
    tick();
    idle();

    // Back-to-back unmapped requests, one response per cycle
    request(32'h8000_0000, 1'b0, 32'h0);
    settle();
    chk("b2b_gnt0", {31'b0, data_gnt_o}, 32'd1);
    expect_rsp(32'h0, 1'b1);
    tick();
    data_addr_i = 32'h9000_0000;
    settle();
    chk("b2b_gnt1", {31'b0, data_gnt_o}, 32'd1);
    chk("b2b_rvalid1", {31'b0, data_rvalid_o}, 32'd1);
    expect_rsp(32'h0, 1'b1);
    tick();
    idle();
    settle();
    chk("b2b_rvalid2", {31'b0, data_rvalid_o}, 32'd1);
    tick();
    settle();
    chk("b2b_idle", {31'b0, data_rvalid_o}, 32'd0);
    tick();

    // Reset with a PERI read outstanding, then a stray peri_rvalid
    request(32'h1A10_0010, 1'b0, 32'h0);
    peri_gnt = 1'b1;
    settle();
    chk("rs_gnt", {31'b0, data_gnt_o}, 32'd1);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peri_rvalid = 1'b1;
    peri_rdata  = 32'hDEAD_BEEF;
    settle();
    chk("rs_stray_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    chk("rs_stray_err", {31'b0, data_err_o}, 32'd0);
    tick();
    idle();
    request(32'h0000_0300, 1'b0, 32'h0);
    ram_gnt = 1'b1;
    settle();
    chk("rs_ram_req", {31'b0, ram_req}, 32'd1);
    chk("rs_ram_gnt", {31'b0, data_gnt_o}, 32'd1);
    expect_rsp(32'h5A5A_0300, 1'b0);
    tick();
    idle();
    ram_rvalid = 1'b1;
    ram_rdata  = 32'h5A5A_0300;
    settle();
    chk("rs_ram_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    tick();
    idle();
    tick();
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
